// File: rtl/mem_ls_pkg.sv
// mem_ls_pkg: opcodes, instruction field positions and FSM states for mem_ls_seq.
package mem_ls_pkg;

    localparam logic [3:0] OP_LOAD     = 4'b0011;
    localparam logic [3:0] OP_STORE    = 4'b0100;
    localparam logic [3:0] OP_LOAD_PI  = 4'b0101;
    localparam logic [3:0] OP_STORE_PI = 4'b0110;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int FA_MSB = 11;
    localparam int FA_LSB = 6;
    localparam int FB_MSB = 5;
    localparam int FB_LSB = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_ADDR,
        S_MAR,
        S_ST_DRV,
        S_ST_MEM,
        S_LD_MEM,
        S_LD_WB,
        S_INC,
        S_DONE
    } state_t;

endpackage

// File: rtl/reg_sel_dec.sv
// reg_sel_dec: 6-bit register index to one-hot enable vector, with range check.
module reg_sel_dec #(
    parameter int NUM_REGS = 4
) (
    input  logic [5:0]          i_idx,
    output logic [NUM_REGS-1:0] o_oh,
    output logic                o_valid
);

    localparam logic [6:0] LIM = 7'(NUM_REGS);

    assign o_valid = {1'b0, i_idx} < LIM;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_oh
        assign o_oh[i] = (i_idx == 6'(i));
    end

endmodule

// File: rtl/mem_ls_seq.sv
// mem_ls_seq: load/store sequencer driving register, MAR, MDR and memory strobes.
// Optional post-increment opcodes and o_inc_en enabled by MEM_LS_POSTINC_EN.
module mem_ls_seq
    import mem_ls_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [15:0]         i_instr,
    input  logic                i_mem_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic                o_pc_inc,
    output logic [NUM_REGS-1:0] o_reg_out_en,
    output logic [NUM_REGS-1:0] o_reg_in_en,
    output logic                o_mar_en,
    output logic                o_mdr_en_write,
    output logic                o_mdr_en_read,
    output logic                o_mdr_out,
    output logic                o_mem_en,
`ifdef MEM_LS_POSTINC_EN
    output logic                o_inc_en,
`endif
    output logic                o_mem_rw
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1) + 1;

    state_t              r_state;
    state_t              w_nxt;
    logic [15:0]         r_instr;
    logic [CW-1:0]       r_cnt;
    logic                r_ld_mem;
    logic [3:0]          w_op;
    logic [NUM_REGS-1:0] w_a_oh;
    logic [NUM_REGS-1:0] w_b_oh;
    logic                w_a_ok;
    logic                w_b_ok;
    logic                w_pi;
    logic                w_load;
    logic                w_legal;
    logic                w_tmo;
    logic                w_fail;

    reg_sel_dec #(.NUM_REGS(NUM_REGS)) u_dec_a (
        .i_idx   (r_instr[FA_MSB:FA_LSB]),
        .o_oh    (w_a_oh),
        .o_valid (w_a_ok)
    );

    reg_sel_dec #(.NUM_REGS(NUM_REGS)) u_dec_b (
        .i_idx   (r_instr[FB_MSB:FB_LSB]),
        .o_oh    (w_b_oh),
        .o_valid (w_b_ok)
    );

    assign w_op = r_instr[OP_MSB:OP_LSB];
`ifdef MEM_LS_POSTINC_EN
    assign w_pi = (w_op == OP_LOAD_PI) || (w_op == OP_STORE_PI);
`else
    assign w_pi = 1'b0;
`endif
    assign w_load  = (w_op == OP_LOAD) || (w_pi && w_op == OP_LOAD_PI);
    assign w_legal = (w_load || w_op == OP_STORE || w_pi) && w_a_ok && w_b_ok;
    // A ready in the final wait cycle still wins over the timeout.
    assign w_tmo   = (MEM_TIMEOUT > 0) && (r_cnt == CW'(MEM_TIMEOUT)) && !i_mem_ready;

    always_comb begin
        w_nxt  = r_state;
        w_fail = 1'b0;
        case (r_state)
            S_IDLE:   w_nxt = i_start ? S_CHECK : S_IDLE;
            S_CHECK: begin
                w_nxt  = w_legal ? S_ADDR : S_DONE;
                w_fail = !w_legal;
            end
            S_ADDR:   w_nxt = S_MAR;
            S_MAR:    w_nxt = w_load ? S_LD_MEM : S_ST_DRV;
            S_ST_DRV: w_nxt = S_ST_MEM;
            S_ST_MEM: begin
                w_nxt  = i_mem_ready ? (w_pi ? S_INC : S_DONE) : (w_tmo ? S_DONE : S_ST_MEM);
                w_fail = w_tmo;
            end
            S_LD_MEM: begin
                w_nxt  = i_mem_ready ? S_LD_WB : (w_tmo ? S_DONE : S_LD_MEM);
                w_fail = w_tmo;
            end
            S_LD_WB:  w_nxt = w_pi ? S_INC : S_DONE;
            S_INC:    w_nxt = S_DONE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state        <= S_IDLE;
            r_instr        <= '0;
            r_cnt          <= '0;
            r_ld_mem       <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_pc_inc       <= 1'b0;
            o_reg_out_en   <= '0;
            o_reg_in_en    <= '0;
            o_mar_en       <= 1'b0;
            o_mdr_en_write <= 1'b0;
            o_mdr_out      <= 1'b0;
            o_mem_en       <= 1'b0;
            o_mem_rw       <= 1'b0;
`ifdef MEM_LS_POSTINC_EN
            o_inc_en       <= 1'b0;
`endif
        end else begin
            r_state        <= w_nxt;
            r_instr        <= (r_state == S_IDLE && i_start) ? i_instr : r_instr;
            r_cnt          <= (r_state == S_ST_MEM || r_state == S_LD_MEM) ? r_cnt + 1'b1 : '0;
            r_ld_mem       <= w_nxt == S_LD_MEM;
            o_busy         <= w_nxt != S_IDLE;
            o_done         <= w_nxt == S_DONE;
            o_err          <= (w_nxt == S_DONE) && w_fail;
            o_pc_inc       <= w_nxt == S_ADDR;
            o_reg_out_en   <= (w_nxt == S_ADDR || w_nxt == S_MAR || w_nxt == S_INC) ? w_a_oh :
                              (w_nxt == S_ST_DRV) ? w_b_oh : '0;
            o_reg_in_en    <= (w_nxt == S_LD_WB) ? w_b_oh : (w_nxt == S_INC) ? w_a_oh : '0;
            o_mar_en       <= w_nxt == S_MAR;
            o_mdr_en_write <= w_nxt == S_ST_DRV;
            o_mdr_out      <= w_nxt == S_LD_WB;
            o_mem_en       <= (w_nxt == S_ST_MEM) || (w_nxt == S_LD_MEM);
            o_mem_rw       <= w_nxt == S_LD_MEM;
`ifdef MEM_LS_POSTINC_EN
            o_inc_en       <= w_nxt == S_INC;
`endif
        end
    end

    assign o_mdr_en_read = r_ld_mem && i_mem_ready;

endmodule
